// File: rtl/err_eval_pkg.sv
// Shared sizing, sweep state encoding and helpers for the approximate-multiplier error sweeper.
package err_eval_pkg;

  localparam int DEF_WIDTH = 32'sd8;
  localparam int DEF_SUM_W = 32'sd32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } sweep_state_e;

  function automatic int unsigned pair_count(input int width);
    return 32'd1 << (32'd2 * width);
  endfunction

  localparam int unsigned PAIR_COUNT = pair_count(DEF_WIDTH);

endpackage

// File: rtl/approx_mul_err_sweep_if.sv
// Operand/product/result bundle between the sweeper (slave) and its driver/consumer (master).
// ERR_BIAS_EN adds the signed err_bias result.
interface approx_mul_err_sweep_if import err_eval_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SUM_W = DEF_SUM_W
);
  logic                   start;
  logic                   abort;
  logic [WIDTH-1:0]       op_a;
  logic [WIDTH-1:0]       op_b;
  logic [2*WIDTH-1:0]     p_approx;
  logic                   busy;
  logic                   result_valid;
  logic                   result_ready;
  logic [2*WIDTH:0]       err_count;
  logic [SUM_W-1:0]       sum_abs_err;
  logic [2*WIDTH-1:0]     max_abs_err;
`ifdef ERR_BIAS_EN
  logic signed [SUM_W:0]  err_bias;

  modport master (
    output start, abort, p_approx, result_ready,
    input  op_a, op_b, busy, result_valid, err_count, sum_abs_err, max_abs_err, err_bias
  );
  modport slave (
    input  start, abort, p_approx, result_ready,
    output op_a, op_b, busy, result_valid, err_count, sum_abs_err, max_abs_err, err_bias
  );
`else
  modport master (
    output start, abort, p_approx, result_ready,
    input  op_a, op_b, busy, result_valid, err_count, sum_abs_err, max_abs_err
  );
  modport slave (
    input  start, abort, p_approx, result_ready,
    output op_a, op_b, busy, result_valid, err_count, sum_abs_err, max_abs_err
  );
`endif
endinterface

// File: rtl/err_stat_acc.sv
// Compare stage plus error count / saturating sum / max accumulators for one sweep.
// ERR_BIAS_EN adds a saturating signed bias accumulator (err_bias).
module err_stat_acc import err_eval_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SUM_W = DEF_SUM_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  cap_en,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  input  logic [2*WIDTH-1:0]    p_approx,
  output logic [2*WIDTH:0]      err_count,
  output logic [SUM_W-1:0]      sum_abs_err,
  output logic [2*WIDTH-1:0]    max_abs_err
`ifdef ERR_BIAS_EN
  ,
  output logic signed [SUM_W:0] err_bias
`endif
);
  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]  exact_s;
  logic [PW-1:0]  stg_p_r;
  logic [PW-1:0]  stg_exact_r;
  logic           stg_vld_r;
  logic [PW:0]    diff_s;
  logic [PW:0]    neg_s;
  logic [PW-1:0]  abs_s;
  logic [SUM_W:0] sum_ext_s;
  logic [SUM_W-1:0] sum_nx_s;
  logic [PW:0]    cnt_r;
  logic [SUM_W-1:0] sum_r;
  logic [PW-1:0]  max_r;

  assign exact_s = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};

  // Difference is one bit wider than the product so its sign is exact.
  always_comb begin
    diff_s = {1'b0, stg_p_r} - {1'b0, stg_exact_r};
    neg_s  = -diff_s;
    if (diff_s[PW]) begin
      abs_s = neg_s[PW-1:0];
    end else begin
      abs_s = diff_s[PW-1:0];
    end
    sum_ext_s = {1'b0, sum_r} + {{(SUM_W - PW + 1){1'b0}}, abs_s};
    if (sum_ext_s[SUM_W]) begin
      sum_nx_s = '1;
    end else begin
      sum_nx_s = sum_ext_s[SUM_W-1:0];
    end
  end

  // Capture stage and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_p_r     <= '0;
      stg_exact_r <= '0;
      stg_vld_r   <= 1'b0;
      cnt_r       <= '0;
      sum_r       <= '0;
      max_r       <= '0;
    end else if (clr) begin
      stg_p_r     <= '0;
      stg_exact_r <= '0;
      stg_vld_r   <= 1'b0;
      cnt_r       <= '0;
      sum_r       <= '0;
      max_r       <= '0;
    end else begin
      stg_vld_r <= cap_en;
      if (cap_en) begin
        stg_p_r     <= p_approx;
        stg_exact_r <= exact_s;
      end
      if (stg_vld_r) begin
        if (diff_s != '0) begin
          cnt_r <= cnt_r + {{PW{1'b0}}, 1'b1};
        end
        sum_r <= sum_nx_s;
        if (abs_s > max_r) begin
          max_r <= abs_s;
        end
      end
    end
  end

  assign err_count   = cnt_r;
  assign sum_abs_err = sum_r;
  assign max_abs_err = max_r;

`ifdef ERR_BIAS_EN
  logic [SUM_W:0]   bias_r;
  logic [SUM_W:0]   bias_nx_s;
  logic [SUM_W+1:0] bias_ext_s;

  // Signed add, clamped to the signed min/max of the bias register.
  always_comb begin
    bias_ext_s = {bias_r[SUM_W], bias_r} + {{(SUM_W + 1 - PW){diff_s[PW]}}, diff_s};
    if (bias_ext_s[SUM_W+1] != bias_ext_s[SUM_W]) begin
      if (bias_ext_s[SUM_W+1]) begin
        bias_nx_s = {1'b1, {SUM_W{1'b0}}};
      end else begin
        bias_nx_s = {1'b0, {SUM_W{1'b1}}};
      end
    end else begin
      bias_nx_s = bias_ext_s[SUM_W:0];
    end
  end

  // Bias accumulator shares the clear/enable rules of the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_r <= '0;
    end else if (clr) begin
      bias_r <= '0;
    end else if (stg_vld_r) begin
      bias_r <= bias_nx_s;
    end
  end

  assign err_bias = $signed(bias_r);
`endif

endmodule

// File: rtl/approx_mul_err_sweep.sv
// Exhaustive operand sweeper: drives every (A,B) pair, accumulates error stats, reports via valid/ready.
// ERR_BIAS_EN adds the signed err_bias result.
module approx_mul_err_sweep import err_eval_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SUM_W = DEF_SUM_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  approx_mul_err_sweep_if.slave  bus
);
  localparam int PW = 2 * WIDTH;

  sweep_state_e  state_r;
  sweep_state_e  state_nx_s;
  logic [PW-1:0] idx_r;
  logic          busy_r;
  logic          valid_r;
  logic          clr_s;
  logic          cap_en_s;
  logic          idx_inc_s;
  logic          idx_last_s;

  assign idx_last_s = &idx_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Abort overrides every transition except in IDLE, where it is ignored.
  always_comb begin
    state_nx_s = state_r;
    clr_s      = 1'b0;
    cap_en_s   = 1'b0;
    idx_inc_s  = 1'b0;
    if (bus.abort && (state_r != IDLE)) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_nx_s = SWEEP;
            clr_s      = 1'b1;
          end else begin
            state_nx_s = IDLE;
          end
        end
        SWEEP: begin
          cap_en_s = 1'b1;
          if (idx_last_s) begin
            state_nx_s = DRAIN;
          end else begin
            idx_inc_s = 1'b1;
          end
        end
        DRAIN: begin
          state_nx_s = REPORT;
        end
        REPORT: begin
          if (bus.result_ready) begin
            state_nx_s = IDLE;
          end else begin
            state_nx_s = REPORT;
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

  // Operand index and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= '0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      if (clr_s) begin
        idx_r <= '0;
      end else if (idx_inc_s) begin
        idx_r <= idx_r + {{(PW - 1){1'b0}}, 1'b1};
      end
      busy_r  <= (state_nx_s == SWEEP) || (state_nx_s == DRAIN);
      valid_r <= (state_nx_s == REPORT);
    end
  end

  assign bus.op_a         = idx_r[PW-1:WIDTH];
  assign bus.op_b         = idx_r[WIDTH-1:0];
  assign bus.busy         = busy_r;
  assign bus.result_valid = valid_r;

  err_stat_acc #(
    .WIDTH (WIDTH),
    .SUM_W (SUM_W)
  ) u_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr_s),
    .cap_en      (cap_en_s),
    .op_a        (idx_r[PW-1:WIDTH]),
    .op_b        (idx_r[WIDTH-1:0]),
    .p_approx    (bus.p_approx),
    .err_count   (bus.err_count),
    .sum_abs_err (bus.sum_abs_err),
`ifdef ERR_BIAS_EN
    .err_bias    (bus.err_bias),
`endif
    .max_abs_err (bus.max_abs_err)
  );

endmodule

// File: tb/tb_approx_mul_err_sweep.sv
// Self-checking bench: two 4-bit sweepers (wide and deliberately narrow accumulator) against a pair-by-pair model.
module tb_approx_mul_err_sweep;
  localparam int W      = 4;
  localparam int SW     = 32;
  localparam int SW_SAT = 10;
  localparam int NPAIR  = 256;
  localparam int LAT    = 257;
  localparam longint SAT_MAX  = (longint'(1) << SW_SAT) - 1;
  localparam longint BIAS_MAX = (longint'(1) << SW_SAT) - 1;
  localparam longint BIAS_MIN = -(longint'(1) << SW_SAT);

  typedef struct {
    int     mode;
    longint cnt;
    longint sum;
    longint max;
    longint sum_sat;
    longint bias;
    longint bias_sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   mode;
  logic [7:0] rnd_p [NPAIR];
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [5];

  always #5 clk = ~clk;

  approx_mul_err_sweep_if #(.WIDTH(W), .SUM_W(SW))     bus ();
  approx_mul_err_sweep_if #(.WIDTH(W), .SUM_W(SW_SAT)) bus_sat ();

  approx_mul_err_sweep #(.WIDTH(W), .SUM_W(SW))     u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  approx_mul_err_sweep #(.WIDTH(W), .SUM_W(SW_SAT)) u_sat (.clk(clk), .rst_n(rst_n), .bus(bus_sat));

  // Multiplier under test: 0 exact, 1 zero, 2 bit0 cleared, otherwise table lookup.
  function automatic logic [7:0] model_p(input int m, input logic [3:0] a, input logic [3:0] b,
                                         input logic [7:0] r);
    int e;
    e = int'(a) * int'(b);
    case (m)
      0:       return 8'(e);
      1:       return 8'd0;
      2:       return 8'(e) & 8'hFE;
      default: return r;
    endcase
  endfunction

  assign bus.p_approx     = model_p(mode, bus.op_a, bus.op_b, rnd_p[{bus.op_a, bus.op_b}]);
  assign bus_sat.p_approx = model_p(mode, bus_sat.op_a, bus_sat.op_b, rnd_p[{bus_sat.op_a, bus_sat.op_b}]);

  function automatic vec_t ref_stats(input int m);
    vec_t   v;
    longint d;
    longint ad;
    v = '{m, 0, 0, 0, 0, 0, 0};
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        d  = longint'(model_p(m, 4'(a), 4'(b), rnd_p[a * 16 + b])) - longint'(a * b);
        ad = (d < 0) ? -d : d;
        if (d != 0) v.cnt++;
        v.sum += ad;
        v.sum_sat = (v.sum_sat + ad > SAT_MAX) ? SAT_MAX : v.sum_sat + ad;
        if (ad > v.max) v.max = ad;
        v.bias += d;
        v.bias_sat += d;
        if (v.bias_sat > BIAS_MAX) v.bias_sat = BIAS_MAX;
        if (v.bias_sat < BIAS_MIN) v.bias_sat = BIAS_MIN;
      end
    end
    return v;
  endfunction

  task automatic fill_random(input int m);
    int e;
    int p;
    for (int i = 0; i < NPAIR; i++) begin
      e = (i / 16) * (i % 16);
      if (m == 3) begin
        p = ($urandom_range(0, 3) == 0) ? e + int'($urandom_range(0, 60)) - 30 : e;
        if (p < 0) p = 0;
        if (p > 255) p = 255;
      end else begin
        p = int'($urandom_range(0, 255));
      end
      rnd_p[i] = 8'(p);
    end
  endtask

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    bus.start = v;
    bus_sat.start = v;
  endtask

  task automatic set_abort(input logic v);
    bus.abort = v;
    bus_sat.abort = v;
  endtask

  task automatic set_ready(input logic v);
    bus.result_ready = v;
    bus_sat.result_ready = v;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ops"},   longint'({bus.op_a, bus.op_b, bus_sat.op_a, bus_sat.op_b}), 0);
    check({tag, "_busy"},  longint'(bus.busy | bus_sat.busy), 0);
    check({tag, "_valid"}, longint'(bus.result_valid | bus_sat.result_valid), 0);
    check({tag, "_cnt"},   longint'(bus.err_count), 0);
    check({tag, "_sum"},   longint'(bus.sum_abs_err | bus_sat.sum_abs_err), 0);
    check({tag, "_max"},   longint'(bus.max_abs_err), 0);
  endtask

  function automatic bit stats_match(input vec_t v);
    bit ok;
    ok = (bus.err_count == v.cnt) && (bus.sum_abs_err == v.sum) && (bus.max_abs_err == v.max) &&
         (bus_sat.sum_abs_err == v.sum_sat);
`ifdef ERR_BIAS_EN
    ok = ok && (bus.err_bias == v.bias) && (bus_sat.err_bias == v.bias_sat);
`endif
    return ok;
  endfunction

  task automatic check_stats(input vec_t v, input string tag);
    check({tag, "_cnt"},     longint'(bus.err_count), v.cnt);
    check({tag, "_sum"},     longint'(bus.sum_abs_err), v.sum);
    check({tag, "_max"},     longint'(bus.max_abs_err), v.max);
    check({tag, "_sat_cnt"}, longint'(bus_sat.err_count), v.cnt);
    check({tag, "_sat_sum"}, longint'(bus_sat.sum_abs_err), v.sum_sat);
    check({tag, "_sat_max"}, longint'(bus_sat.max_abs_err), v.max);
`ifdef ERR_BIAS_EN
    check({tag, "_bias"},     longint'(bus.err_bias), v.bias);
    check({tag, "_sat_bias"}, longint'(bus_sat.err_bias), v.bias_sat);
`endif
  endtask

  // Pulse start (optionally with abort, which IDLE must ignore) and wait for result_valid.
  task automatic run_sweep(input vec_t v, input string tag, input bit with_abort);
    int lat;
    bit seq_ok;
    set_start(1'b1);
    if (with_abort) set_abort(1'b1);
    @(negedge clk);
    set_start(1'b0);
    set_abort(1'b0);
    lat = 0;
    seq_ok = 1'b1;
    while (!bus.result_valid && lat < 400) begin
      if (lat <= 255 && {bus.op_a, bus.op_b} != 8'(lat)) seq_ok = 1'b0;
      if (!bus.busy || !bus_sat.busy) seq_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, longint'(lat), LAT);
    check({tag, "_opseq_busy"}, longint'(seq_ok), 1);
    check({tag, "_busy_rep"}, longint'(bus.busy), 0);
    check_stats(v, tag);
  endtask

  task automatic handshake(input vec_t v, input string tag);
    set_ready(1'b1);
    @(negedge clk);
    set_ready(1'b0);
    check({tag, "_hs_valid"}, longint'(bus.result_valid | bus_sat.result_valid), 0);
    check({tag, "_hs_busy"},  longint'(bus.busy), 0);
    @(negedge clk);
    check({tag, "_idle_hold"}, longint'(stats_match(v)), 1);
  endtask

  initial begin
    bit stable;
    bit seen;
    rst_n = 1'b0;
    mode  = 0;
    set_start(1'b0);
    set_abort(1'b0);
    set_ready(1'b0);
    for (int i = 0; i < NPAIR; i++) rnd_p[i] = 8'd0;
    vecs[0] = '{0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 225, 14400, 225, SAT_MAX, -14400, BIAS_MIN};
    vecs[2] = '{2, 64, 64, 1, 64, -64, -64};
    vecs[3] = '{3, 0, 0, 0, 0, 0, 0};
    vecs[4] = '{4, 0, 0, 0, 0, 0, 0};

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      mode = vecs[i].mode;
      if (mode >= 3) begin
        fill_random(mode);
        vecs[i] = ref_stats(mode);
      end
      run_sweep(vecs[i], $sformatf("mode%0d", mode), 1'b0);
      if (i == 1) begin
        // Backpressure with start held high throughout REPORT.
        set_start(1'b1);
        stable = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (!bus.result_valid || !stats_match(vecs[i])) stable = 1'b0;
        end
        check("bp_stable", longint'(stable), 1);
        set_ready(1'b1);
        @(negedge clk);
        set_ready(1'b0);
        set_start(1'b0);
        check("bp_hs_valid", longint'(bus.result_valid), 0);
        check("bp_start_ignored", longint'(bus.busy), 0);
        @(negedge clk);
        check("bp_still_idle", longint'(bus.busy | bus.result_valid), 0);
      end else begin
        handshake(vecs[i], $sformatf("mode%0d", mode));
      end
    end

    // Asynchronous reset in mid-sweep, then a clean rerun.
    mode = 2;
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    repeat (100) @(negedge clk);
    check("op_at_100", longint'({bus.op_a, bus.op_b}), 100);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(vecs[2], "after_reset", 1'b0);
    handshake(vecs[2], "after_reset");

    // Abort in mid-sweep: no result must appear.
    mode = 1;
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    repeat (50) @(negedge clk);
    check("op_at_50", longint'({bus.op_a, bus.op_b}), 50);
    set_abort(1'b1);
    @(negedge clk);
    set_abort(1'b0);
    check("abort_busy", longint'(bus.busy | bus_sat.busy), 0);
    check("abort_valid", longint'(bus.result_valid), 0);
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (bus.result_valid || bus.busy) seen = 1'b1;
    end
    check("abort_quiet", longint'(seen), 0);
    run_sweep(vecs[1], "after_abort", 1'b0);
    handshake(vecs[1], "after_abort");

    // Abort in IDLE is ignored (start still honoured); abort in REPORT drops the result.
    mode = 0;
    run_sweep(vecs[0], "idle_abort", 1'b1);
    set_abort(1'b1);
    @(negedge clk);
    set_abort(1'b0);
    check("report_abort_valid", longint'(bus.result_valid | bus_sat.result_valid), 0);
    check("report_abort_busy", longint'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/approx_mul_err_sweep.md
Name: approx_mul_err_sweep

Overview:
Exhaustive operand sweeper and error accumulator for evolved approximate multipliers such as the multiplier8bit_N candidates. It drives every (A,B) operand pair into a combinational approximate multiplier and consumes its product. Each product is compared with an exact reference product, and error statistics are accumulated for GA fitness evaluation. Results are presented through a valid/ready handshake.

Parameters:
WIDTH, 8, operand width; the product is 2*WIDTH bits.
SUM_W, 32, width of the sum-of-absolute-error accumulator; it must hold (2^WIDTH*(2^WIDTH-1)/2)^2.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse that begins a sweep; honoured only in IDLE
abort  in  1  synchronous abort; returns to IDLE with no result
op_a  out  WIDTH  operand A to the multiplier under test (registered)
op_b  out  WIDTH  operand B to the multiplier under test (registered)
p_approx  in  2*WIDTH  combinational product from the multiplier under test
busy  out  1  high in SWEEP and DRAIN
result_valid  out  1  statistics valid, high in REPORT
result_ready  in  1  consumer accepts the result
err_count  out  2*WIDTH+1  number of pairs with p_approx != exact
sum_abs_err  out  SUM_W  sum over all pairs of |p_approx - exact|
max_abs_err  out  2*WIDTH  maximum |p_approx - exact|

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE.
  - op_a, op_b, busy, result_valid, err_count, sum_abs_err, max_abs_err and the index counter all = 0.
  - Any sweep in progress is discarded.
- States are IDLE, SWEEP, DRAIN and REPORT.
- IDLE:
  - start=1 moves to SWEEP.
  - The same edge clears all accumulators and the index, and drives op_a=op_b=0.
- SWEEP:
  - A 2*WIDTH-bit index idx increments each cycle; op_a = idx[2*WIDTH-1:WIDTH], op_b = idx[WIDTH-1:0], both registered.
  - Each cycle, p_approx and the exact product op_a*op_b (computed from the same registered operands) are captured into a stage register.
  - In the following cycle the stage compares the two values and updates the accumulators.
  - Total latency from operand drive to accumulation is 2 cycles.
  - When idx = 2^(2*WIDTH)-1 has been driven, the next state is DRAIN. The index does not wrap into a second pass.
- DRAIN:
  - Lasts exactly 1 cycle and accumulates the last captured pair, then moves to REPORT.
  - A full sweep takes 2^(2*WIDTH)+1 cycles from start to result_valid. For WIDTH=8 this is 65537 cycles.
- Arithmetic:
  - |diff| is computed in 2*WIDTH+1 bits and truncated to 2*WIDTH, which is always sufficient for unsigned operands.
  - err_count increments when the difference is nonzero.
  - max_abs_err updates on a strict greater-than.
  - sum_abs_err saturates at all-ones; it never wraps.
- REPORT:
  - result_valid=1.
  - Statistics are held stable until result_ready=1. The handshake completes on that edge and the state returns to IDLE.
  - Statistics retain their values in IDLE until the next start.
- start outside IDLE is ignored.
- start and result_ready asserted on the same cycle in REPORT: the handshake completes and start is ignored.
- abort=1 in SWEEP, DRAIN or REPORT: on the next edge the state returns to IDLE, with busy=0 and result_valid=0.
  - The accumulators are left as-is and are undefined for consumption.
  - abort has priority over every other transition.
  - In IDLE, abort has no effect.
- p_approx is sampled only in SWEEP. Its value in other states is don't-care.

Optional Feature:
- Macro: ERR_BIAS_EN.
- When defined:
  - Adds an output port err_bias, signed, SUM_W+1 bits.
  - err_bias is the signed sum of (p_approx - exact) over the sweep (mean-error bias numerator).
  - Its reset, clear, saturation (at signed min/max), hold and abort rules match sum_abs_err.
- When undefined: the port and the bias logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package err_eval_pkg holds:
  - the state enum (IDLE, SWEEP, DRAIN, REPORT);
  - default WIDTH/SUM_W constants;
  - a localparam for the pair count, 2^(2*WIDTH).
- One sub-module: err_stat_acc. It contains the compare stage plus the count/sum/max (and optional bias) accumulators, with clear/enable inputs driven by the FSM.

Test Plan:
1. DUT is an exact multiplier, then start -> result_valid after 65537 cycles; err_count=0, sum_abs_err=0, max_abs_err=0 (err_bias=0 when ERR_BIAS_EN).
2. DUT stub returns 0 -> err_count=65025 (511 zero-product pairs excluded), sum_abs_err=1065369600, max_abs_err=65025 (err_bias=-1065369600).
3. DUT stub returns the exact product with bit0 forced to 0 -> err_count=16384, sum_abs_err=16384, max_abs_err=1.
4. Backpressure: result_ready held low for 10 cycles in REPORT -> result_valid and all statistics stable; the handshake completes on the first ready cycle and the state returns to IDLE; start asserted during REPORT is ignored.
5. rst_n pulsed low at idx=1000 -> all outputs 0 immediately; a new start gives the same results as the corresponding full-sweep scenario.
6. abort at idx=500 -> IDLE next cycle, busy=0, result_valid never asserts; a subsequent start produces full, correct results.
